lcd_cmd_queue: RTL and testbench

//  Command FIFO and sequencer directly upstream of the LCD serial transceiver (lcd_tcvr). Buffers

---
 rtl/lcd_cmd_queue.sv | 194 +++++++++++++++++++
 tb/tb_lcd_cmd_queue.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_cmd_queue.sv
// Command FIFO and single-outstanding sequencer feeding the LCD serial transceiver.
// Entries are {write, addr[6:0], data[7:0]}; one command is in flight at a time and its
// address/data are held on the transceiver inputs until the transceiver is idle again.
module lcd_cmd_queue #(
   parameter int unsigned DEPTH_LOG2     = 2,
   parameter int unsigned TIMEOUT_CYCLES = 65535
) (
   input  logic                  i_clock,
   input  logic                  i_reset,
   input  logic                  i_cmdValid,
   input  logic                  i_cmdWrite,
   input  logic [6:0]            i_cmdAddress,
   input  logic [7:0]            i_cmdData,
   input  logic                  i_flush,
   output logic                  o_cmdReady,
   output logic [DEPTH_LOG2:0]   o_count,
   output logic                  o_txBegin,
   output logic                  o_rxBegin,
   output logic [6:0]            o_address,
   output logic [7:0]            o_txData,
   input  logic                  i_txBusy,
   input  logic                  i_rxBusy,
   input  logic                  i_txDone,
   input  logic                  i_rxDone,
   input  logic [7:0]            i_rxData,
   output logic                  o_rdValid,
   output logic [7:0]            o_rdData,
   output logic [6:0]            o_rdAddress,
   output logic                  o_idle,
   output logic                  o_timeout,
   output logic                  o_overflow
);

   localparam int unsigned Depth = 2 ** DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] FullCount = {1'b1, {DEPTH_LOG2{1'b0}}};
   localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      StIdle, StIssue, StWaitBusy, StWaitDone, StWaitRelease
   } state_e;

   logic [15:0]           mem_q [Depth];
   logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [DEPTH_LOG2:0]   count_q, count_d;
   state_e                state_q, state_d;
   logic [15:0]           timer_q, timer_d;
   logic                  write_q, write_d;
   logic [6:0]            addr_q, addr_d;
   logic [7:0]            tx_data_q, tx_data_d;
   logic                  rd_valid_q, rd_valid_d;
   logic [7:0]            rd_data_q, rd_data_d;
   logic [6:0]            rd_addr_q, rd_addr_d;
   logic                  timeout_q, timeout_d;
   logic                  overflow_q, overflow_d;
   logic                  idle_q, idle_d;

   logic        full, push, pop, lines_quiet, busy_match, done_match, in_wait;
   logic [15:0] head;

   // FIFO bookkeeping; flush discards queued entries and wins over a same-cycle push
   always_comb begin
      full        = (count_q == FullCount);
      push        = i_cmdValid & ~full & ~i_flush;
      lines_quiet = ~(i_txBusy | i_rxBusy | i_txDone | i_rxDone);
      pop         = (state_q == StIdle) & (count_q != '0) & lines_quiet & ~i_flush;
      head        = mem_q[rd_ptr_q];
      wr_ptr_d    = push ? wr_ptr_q + DEPTH_LOG2'(1) : wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      if (i_flush) begin
         rd_ptr_d = wr_ptr_q;
         count_d  = '0;
      end else begin
         if (pop) rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
         if (push && !pop) count_d = count_q + (DEPTH_LOG2 + 1)'(1);
         else if (pop && !push) count_d = count_q - (DEPTH_LOG2 + 1)'(1);
      end
   end

   // Sequencer next state, per-wait-state timeout and read-return capture
   always_comb begin
      state_d    = state_q;
      timer_d    = '0;
      write_d    = write_q;
      addr_d     = addr_q;
      tx_data_d  = tx_data_q;
      rd_valid_d = 1'b0;
      rd_data_d  = rd_data_q;
      rd_addr_d  = rd_addr_q;
      timeout_d  = 1'b0;
      overflow_d = i_cmdValid & full & ~i_flush;
      busy_match = write_q ? i_txBusy : i_rxBusy;
      done_match = write_q ? i_txDone : i_rxDone;
      in_wait    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (pop) begin
               write_d   = head[15];
               addr_d    = head[14:8];
               tx_data_d = head[15] ? head[7:0] : 8'h00;
               state_d   = StIssue;
            end
         end
         StIssue: state_d = StWaitBusy;
         StWaitBusy: begin
            in_wait = 1'b1;
            if (busy_match) state_d = StWaitDone;
         end
         StWaitDone: begin
            in_wait = 1'b1;
            if (done_match) begin
               state_d = StWaitRelease;
               if (!write_q) begin
                  rd_valid_d = 1'b1;
                  rd_data_d  = i_rxData;
                  rd_addr_d  = addr_q;
               end
            end
         end
         StWaitRelease: begin
            in_wait = 1'b1;
            if (!done_match && !busy_match) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
      // Progress beats timeout; the timer restarts on every state entry
      if (in_wait && state_d == state_q) begin
         if (timer_q == TimeoutLast) begin
            state_d   = StIdle;
            timeout_d = 1'b1;
         end else begin
            timer_d = timer_q + 16'd1;
         end
      end
      idle_d = (count_d == '0) & (state_d == StIdle);
   end

   // Entry storage; no reset needed since count gates every read
   always_ff @(posedge i_clock) begin
      if (push) mem_q[wr_ptr_q] <= {i_cmdWrite, i_cmdAddress, i_cmdData};
   end

   // State registers
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         state_q    <= StIdle;
         timer_q    <= '0;
         write_q    <= 1'b0;
         addr_q     <= '0;
         tx_data_q  <= '0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
         rd_addr_q  <= '0;
         timeout_q  <= 1'b0;
         overflow_q <= 1'b0;
         idle_q     <= 1'b1;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         state_q    <= state_d;
         timer_q    <= timer_d;
         write_q    <= write_d;
         addr_q     <= addr_d;
         tx_data_q  <= tx_data_d;
         rd_valid_q <= rd_valid_d;
         rd_data_q  <= rd_data_d;
         rd_addr_q  <= rd_addr_d;
         timeout_q  <= timeout_d;
         overflow_q <= overflow_d;
         idle_q     <= idle_d;
      end
   end

   // Begin strobes decode straight from the state so reset drops them immediately
   always_comb begin
      o_cmdReady  = ~full;
      o_count     = count_q;
      o_txBegin   = (state_q == StIssue) & write_q;
      o_rxBegin   = (state_q == StIssue) & ~write_q;
      o_address   = addr_q;
      o_txData    = tx_data_q;
      o_rdValid   = rd_valid_q;
      o_rdData    = rd_data_q;
      o_rdAddress = rd_addr_q;
      o_idle      = idle_q;
      o_timeout   = timeout_q;
      o_overflow  = overflow_q;
   end

endmodule

// File: tb/tb_lcd_cmd_queue.sv
// Bench for lcd_cmd_queue: a transaction-level model (expected-command queue, occupancy,
// in-flight tracking) checked every cycle, a simple transceiver responder, directed scenarios.
module tb_lcd_cmd_queue;
   localparam int Depth = 4;
   localparam int Tmo   = 16;

   logic       i_clock, i_reset, i_cmdValid, i_cmdWrite, i_flush;
   logic [6:0] i_cmdAddress;
   logic [7:0] i_cmdData, i_rxData;
   logic       i_txBusy, i_rxBusy, i_txDone, i_rxDone;
   logic       o_cmdReady, o_txBegin, o_rxBegin, o_rdValid, o_idle, o_timeout, o_overflow;
   logic [2:0] o_count;
   logic [6:0] o_address, o_rdAddress;
   logic [7:0] o_txData, o_rdData;

   lcd_cmd_queue #(.DEPTH_LOG2(2), .TIMEOUT_CYCLES(Tmo)) dut (
      .i_clock(i_clock), .i_reset(i_reset), .i_cmdValid(i_cmdValid), .i_cmdWrite(i_cmdWrite),
      .i_cmdAddress(i_cmdAddress), .i_cmdData(i_cmdData), .i_flush(i_flush),
      .o_cmdReady(o_cmdReady), .o_count(o_count), .o_txBegin(o_txBegin), .o_rxBegin(o_rxBegin),
      .o_address(o_address), .o_txData(o_txData), .i_txBusy(i_txBusy), .i_rxBusy(i_rxBusy),
      .i_txDone(i_txDone), .i_rxDone(i_rxDone), .i_rxData(i_rxData), .o_rdValid(o_rdValid),
      .o_rdData(o_rdData), .o_rdAddress(o_rdAddress), .o_idle(o_idle), .o_timeout(o_timeout),
      .o_overflow(o_overflow)
   );

   initial begin
      i_clock = 1'b0;
      forever #5 i_clock = ~i_clock;
   end

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Transceiver responder controls
   int       xmode    = 0;  // 0 normal, 2 mute (no busy, late done level)
   int       busy_len = 3;
   bit [7:0] rx_val   = 8'h00;

   // Model state
   typedef struct {bit w; bit [6:0] a; bit [7:0] d;} cmd_t;
   cmd_t     expq[$];
   cmd_t     cur;
   int       cnt_m, cyc, b_cyc;
   bit       inflight, busy_seen, done_seen, exp_begin, push_p, ovf_p, flush_p;
   bit       rdv_p, tmo_p, rel_p, bg_s, bm_s, dm_s;
   bit [7:0] rdd_p;
   bit [6:0] rda_p;
   int       n_tx, n_rx, n_rdv, n_tmo, n_ovf;
   bit [7:0] last_rdd;
   bit [6:0] last_rda;

   // Model update and per-cycle comparison, sampled mid-cycle
   always @(negedge i_clock) begin
      cyc++;
      if (i_reset) begin
         expq.delete();
         cnt_m = 0; inflight = 0; busy_seen = 0; done_seen = 0; exp_begin = 0;
         push_p = 0; ovf_p = 0; flush_p = 0; rdv_p = 0; tmo_p = 0; rel_p = 0;
      end else begin
         bg_s = o_txBegin | o_rxBegin;
         if (rel_p || tmo_p) inflight = 0;
         chk("begin_timing", int'(bg_s), int'(exp_begin));
         cnt_m = flush_p ? 0 : cnt_m + int'(push_p) - int'(bg_s);
         if (bg_s) begin
            chk("begin_has_queued_cmd", int'(expq.size() != 0), 1);
            if (expq.size() != 0) begin
               cur = expq.pop_front();
               chk("begin_kind", int'(o_txBegin), int'(cur.w));
            end
            inflight = 1; busy_seen = 0; done_seen = 0; b_cyc = cyc;
            n_tx += int'(o_txBegin);
            n_rx += int'(o_rxBegin);
         end
         chk("count", int'(o_count), cnt_m);
         chk("cmd_ready", int'(o_cmdReady), int'(cnt_m < Depth));
         chk("overflow", int'(o_overflow), int'(ovf_p));
         chk("timeout", int'(o_timeout), int'(tmo_p));
         chk("rd_valid", int'(o_rdValid), int'(rdv_p));
         if (rdv_p) begin
            chk("rd_data", int'(o_rdData), int'(rdd_p));
            chk("rd_address", int'(o_rdAddress), int'(rda_p));
         end
         chk("idle", int'(o_idle), int'(cnt_m == 0 && !inflight));
         if (inflight) begin
            chk("address_hold", int'(o_address), int'(cur.a));
            chk("tx_data_hold", int'(o_txData), cur.w ? int'(cur.d) : 0);
         end
         if (o_rdValid) begin
            n_rdv++; last_rdd = o_rdData; last_rda = o_rdAddress;
         end
         n_tmo += int'(o_timeout);
         n_ovf += int'(o_overflow);
         // Predictions for the next cycle
         rel_p = 0; tmo_p = 0; rdv_p = 0;
         if (inflight) begin
            bm_s = cur.w ? i_txBusy : i_rxBusy;
            dm_s = cur.w ? i_txDone : i_rxDone;
            if (done_seen && !bm_s && !dm_s) rel_p = 1;
            else if (busy_seen && !done_seen && dm_s) begin
               done_seen = 1;
               if (!cur.w) begin
                  rdv_p = 1; rdd_p = i_rxData; rda_p = cur.a;
               end
            end
            if (!busy_seen && bm_s) busy_seen = 1;
            else if (!busy_seen && cyc - b_cyc == Tmo) tmo_p = 1;
         end
         flush_p = i_flush;
         push_p  = i_cmdValid && cnt_m < Depth && !i_flush;
         ovf_p   = i_cmdValid && cnt_m == Depth && !i_flush;
         if (i_flush) expq.delete();
         else if (push_p) expq.push_back('{w: i_cmdWrite, a: i_cmdAddress, d: i_cmdData});
         exp_begin = !inflight && cnt_m > 0 && !i_flush &&
                     !(i_txBusy || i_rxBusy || i_txDone || i_rxDone);
      end
   end

   // Transceiver responder: busy from begin+2, then a two-cycle done level
   initial begin : xcvr
      int m;
      bit w;
      i_txBusy = 0; i_rxBusy = 0; i_txDone = 0; i_rxDone = 0; i_rxData = 8'h00;
      forever begin
         @(negedge i_clock);
         if (!i_reset && (o_txBegin || o_rxBegin)) begin
            w = o_txBegin;
            m = xmode;
            if (m == 2) begin
               repeat (10) @(posedge i_clock);
               #1 if (w) i_txDone = 1; else i_rxDone = 1;
               repeat (12) @(posedge i_clock);
               #1 begin i_txDone = 0; i_rxDone = 0; end
            end else begin
               repeat (2) @(posedge i_clock);
               #1 if (w) i_txBusy = 1; else i_rxBusy = 1;
               repeat (busy_len) @(posedge i_clock);
               #1 begin
                  i_txBusy = 0; i_rxBusy = 0; i_rxData = rx_val;
                  if (w) i_txDone = 1; else i_rxDone = 1;
               end
               repeat (2) @(posedge i_clock);
               #1 begin i_txDone = 0; i_rxDone = 0; end
            end
         end
      end
   end

   task automatic push_cmd(input bit w, input bit [6:0] a, input bit [7:0] d);
      i_cmdValid = 1; i_cmdWrite = w; i_cmdAddress = a; i_cmdData = d;
      @(posedge i_clock); #1;
      i_cmdValid = 0;
   endtask

   task automatic wait_quiet(input string name, input int budget);
      int k;
      k = 0;
      while (!(o_idle && !i_txBusy && !i_rxBusy && !i_txDone && !i_rxDone) && k < budget) begin
         @(posedge i_clock); #1;
         k++;
      end
      chk(name, int'(k < budget), 1);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int bt, br, bv, bo, k;
      i_reset = 1; i_cmdValid = 0; i_cmdWrite = 0; i_cmdAddress = 0; i_cmdData = 0; i_flush = 0;
      #2;
      chk("reset_count", int'(o_count), 0);
      chk("reset_ready", int'(o_cmdReady), 1);
      chk("reset_idle", int'(o_idle), 1);
      chk("reset_begin", int'(o_txBegin | o_rxBegin), 0);
      @(posedge i_clock); #1 i_reset = 0;
      repeat (2) @(posedge i_clock); #1;

      // 1: single write
      bt = n_tx; bv = n_rdv;
      push_cmd(1, 7'h12, 8'hA5);
      wait_quiet("t1_quiet_bound", 100);
      chk("t1_tx_pulses", n_tx - bt, 1);
      chk("t1_no_rd_valid", n_rdv - bv, 0);
      chk("t1_idle", int'(o_idle), 1);

      // 2: single read
      br = n_rx; bv = n_rdv; rx_val = 8'h3C;
      push_cmd(0, 7'h05, 8'hEE);
      wait_quiet("t2_quiet_bound", 100);
      chk("t2_rx_pulses", n_rx - br, 1);
      chk("t2_rd_valid_count", n_rdv - bv, 1);
      chk("t2_rd_data", int'(last_rdd), 8'h3C);
      chk("t2_rd_address", int'(last_rda), 7'h05);

      // 3: fill the queue behind a slow transfer, then overflow
      bt = n_tx; br = n_rx; bo = n_ovf; busy_len = 8; rx_val = 8'h77;
      push_cmd(1, 7'h10, 8'h01);
      push_cmd(0, 7'h11, 8'hE2);
      push_cmd(1, 7'h12, 8'h03);
      push_cmd(0, 7'h13, 8'hE4);
      push_cmd(1, 7'h14, 8'h05);
      push_cmd(1, 7'h15, 8'h06);
      chk("t3_overflow_pulse", int'(o_overflow), 1);
      chk("t3_count_full", int'(o_count), 4);
      chk("t3_not_ready", int'(o_cmdReady), 0);
      wait_quiet("t3_quiet_bound", 300);
      chk("t3_issued", (n_tx - bt) + (n_rx - br), 5);
      chk("t3_overflow_count", n_ovf - bo, 1);
      busy_len = 3;

      // 4: transceiver never goes busy, then a late done level
      bt = n_tx; bo = n_tmo; xmode = 2;
      push_cmd(1, 7'h20, 8'h11);
      push_cmd(1, 7'h21, 8'h22);
      k = 0;
      while (n_tx == bt && k < 50) begin
         @(posedge i_clock); #1;
         k++;
      end
      chk("t4_first_begin_bound", int'(k < 50), 1);
      xmode = 0;
      wait_quiet("t4_quiet_bound", 200);
      chk("t4_timeouts", n_tmo - bo, 1);
      chk("t4_tx_pulses", n_tx - bt, 2);

      // 5: flush while the first of three writes is in flight
      bt = n_tx;
      push_cmd(1, 7'h30, 8'h31);
      push_cmd(1, 7'h32, 8'h33);
      push_cmd(1, 7'h34, 8'h35);
      i_flush = 1;
      @(posedge i_clock); #1;
      i_flush = 0;
      chk("t5_count_after_flush", int'(o_count), 0);
      wait_quiet("t5_quiet_bound", 100);
      chk("t5_tx_pulses", n_tx - bt, 1);

      // 6: reset during the done wait of a read
      br = n_rx; bv = n_rdv; rx_val = 8'h99;
      push_cmd(0, 7'h33, 8'h00);
      k = 0;
      while (n_rx == br && k < 50) begin
         @(posedge i_clock); #1;
         k++;
      end
      chk("t6_begin_bound", int'(k < 50), 1);
      repeat (2) @(posedge i_clock); #1;
      chk("t6_busy_before_reset", int'(o_idle), 0);
      i_reset = 1;
      #1;
      chk("t6_count", int'(o_count), 0);
      chk("t6_idle", int'(o_idle), 1);
      chk("t6_ready", int'(o_cmdReady), 1);
      chk("t6_begin", int'(o_txBegin | o_rxBegin), 0);
      chk("t6_address", int'(o_address), 0);
      chk("t6_rd_valid", int'(o_rdValid), 0);
      @(posedge i_clock); #1 i_reset = 0;
      rx_val = 8'h5A;
      push_cmd(0, 7'h34, 8'h00);
      wait_quiet("t6_quiet_bound", 100);
      chk("t6_rd_valid_count", n_rdv - bv, 1);
      chk("t6_rd_address", int'(last_rda), 7'h34);
      chk("t6_rd_data", int'(last_rdd), 8'h5A);

      repeat (3) @(posedge i_clock);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
